// File: rtl/lut_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lut_cfg_pkg
// Brief    : Shared types and sizing helpers for the LUT configuration loader.
// Revision : 1.0 - initial release
// ============================================================================
package lut_cfg_pkg;

    localparam int LUT_BITS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic int frame_len(input int num_luts, input int lut_bits);
        return num_luts * lut_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_shift_reg
// Brief    : Shadow shift register (MSB-first fill) with running even parity.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_shift_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             parity
);

    // clr wins so an abort in the same cycle as a bit discards that bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            data   <= '0;
            parity <= 1'b0;
        end else if (shift_en) begin
            data   <= {data[WIDTH-2:0], bit_in};
            parity <= parity ^ bit_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lut_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : lut_cfg_loader
// Brief    : Serial, parity-checked loader committing all LUT configs at once.
// Revision : 1.0 - initial release
// ============================================================================
module lut_cfg_loader #(
    parameter int NUM_LUTS = 4,
    parameter int LUT_BITS = lut_cfg_pkg::LUT_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    input  logic                         cfg_data,
    output logic                         cfg_ready,
    output logic [NUM_LUTS*LUT_BITS-1:0] lut_config,
    output logic                         cfg_done,
    output logic                         cfg_err
);
    import lut_cfg_pkg::*;

    localparam int              FRAME    = frame_len(NUM_LUTS, LUT_BITS);
    localparam int              CNT_W    = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_shift_en;
    logic               w_clr;
    logic               w_commit;
    logic               w_err_set;
    logic [FRAME-1:0]   w_shadow;
    logic               w_parity;

    cfg_shift_reg #(
        .WIDTH (FRAME)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (w_shift_en),
        .clr      (w_clr),
        .bit_in   (cfg_data),
        .data     (w_shadow),
        .parity   (w_parity)
    );

    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        w_shift_en   = 1'b0;
        w_clr        = 1'b0;
        w_commit     = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_clr        = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    w_clr = 1'b1;
                end else if (cfg_valid) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    w_clr        = 1'b1;
                    w_state_next = SHIFT;
                end else if (cfg_valid) begin
                    if (cfg_data == w_parity) begin
                        w_commit  = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            lut_config <= '0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            cfg_done <= w_commit;
            // Counter holds at the terminal count rather than wrapping
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_shift_en && (r_cnt != LAST_CNT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_clr) begin
                cfg_err <= 1'b0;
            end else if (w_err_set) begin
                cfg_err <= 1'b1;
            end
            if (w_commit) begin
                lut_config <= w_shadow;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lut_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_cfg_loader
// Brief    : Scoreboard bench for lut_cfg_loader (4 x 16-bit LUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_cfg_loader;

    localparam int FRAME = 64;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_data;
    logic        cfg_ready;
    logic [63:0] lut_config;
    logic        cfg_done;
    logic        cfg_err;

    int          n_checks;
    int          n_errors;
    logic [63:0] exp_q[$];
    logic [63:0] prev_cfg;
    logic [63:0] rnd;

    lut_cfg_loader #(
        .NUM_LUTS (4),
        .LUT_BITS (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .lut_config (lut_config),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the bit transfers on the next rising edge
    task automatic send_bit(input logic b, input logic gap);
        int guard;
        if (gap) begin
            @(negedge clk);
            cfg_valid = 1'b0;
        end
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = b;
        guard     = 0;
        while (!cfg_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("ready_timeout", {63'b0, cfg_ready}, 64'd1);
    endtask

    task automatic send_frame(input logic [63:0] d, input logic par, input logic gap);
        for (int i = 0; i < FRAME; i++) send_bit(d[63-i], gap);
        send_bit(par, gap);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Full good frame: result must appear exactly one cycle after the parity bit
    task automatic good_frame(input logic [63:0] d, input logic gap);
        start_pulse();
        exp_q.push_back(d);
        send_frame(d, ^d, gap);
        @(posedge clk);
        #1;
        check("done_rise", {63'b0, cfg_done}, 64'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        check("done_fall", {63'b0, cfg_done}, 64'd0);
        prev_cfg = d;
    endtask

    // Scoreboard: every cfg_done pulse must match the oldest expected commit
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && cfg_done) begin
                if (exp_q.size() == 0) check("spurious_done", {63'b0, cfg_done}, 64'd0);
                else check("commit_cfg", lut_config, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prev_cfg  = '0;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cfg",   lut_config,           64'd0);
        check("rst_ready", {63'b0, cfg_ready},   64'd0);
        check("rst_done",  {63'b0, cfg_done},    64'd0);
        check("rst_err",   {63'b0, cfg_err},     64'd0);

        good_frame(64'h0000_0000_0000_0001, 1'b0);
        check("good_cfg", lut_config, 64'h0000_0000_0000_0001);

        // Bad parity: no commit, sticky error, config held
        start_pulse();
        send_frame(64'h0000_0000_0000_0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("bad_done", {63'b0, cfg_done}, 64'd0);
        check("bad_err",  {63'b0, cfg_err},  64'd1);
        check("bad_hold", lut_config, prev_cfg);
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("err_sticky", {63'b0, cfg_err}, 64'd1);
        start_pulse();
        check("err_clear", {63'b0, cfg_err}, 64'd0);
        check("err_clear_hold", lut_config, prev_cfg);

        // Backpressure: valid low every other cycle
        good_frame(64'hFFFF_0000_A5A5_0001, 1'b1);
        check("gap_cfg", lut_config, 64'hFFFF_0000_A5A5_0001);

        // Abort after 20 bits; the start cycle itself comes from IDLE with valid high
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        rnd = {$urandom, $urandom};
        for (int i = 0; i < 20; i++) send_bit(rnd[i], 1'b0);
        start_pulse();
        check("abort_hold", lut_config, prev_cfg);
        cfg_valid = 1'b0;
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        send_frame(64'h1234_5678_9ABC_DEF0, ^64'h1234_5678_9ABC_DEF0, 1'b0);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        check("abort_cfg", lut_config, 64'h1234_5678_9ABC_DEF0);
        prev_cfg = 64'h1234_5678_9ABC_DEF0;

        for (int k = 0; k < 3; k++) begin
            rnd = {$urandom, $urandom};
            good_frame(rnd, k[0]);
            check("rand_cfg", lut_config, rnd);
        end

        // Reset in the middle of a frame
        good_frame(64'h0000_0000_0000_0001, 1'b0);
        start_pulse();
        for (int i = 0; i < 30; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cfg",   lut_config,         64'd0);
        check("mid_rst_ready", {63'b0, cfg_ready}, 64'd0);
        check("mid_rst_err",   {63'b0, cfg_err},   64'd0);
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", {63'b0, cfg_ready}, 64'd0);
        check("post_rst_cfg",   lut_config,         64'd0);
        good_frame(64'hDEAD_BEEF_0F0F_8001, 1'b0);
        check("post_rst_commit", lut_config, 64'hDEAD_BEEF_0F0F_8001);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
